fetch_decode_alu: RTL and testbench
===================================

Name: fetch_decode_alu

Overview:
- Single-cycle MIPS-subset front end: PC register (fetch), combinational instruction decoder and 32-bit ALU in one block.
- Sits between instruction/data memory, the register file and the SPI register block inside the CPU top level.
- Takes the current instruction plus register read data, and produces the next PC, register-file addresses and controls, memory command, SPI control and ALU result.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted
- W_CPU, 32, datapath width (fixed at 32; other values unsupported)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst  in  32  current instruction (from memory at address pc)
- rd1  in  32  register file read data, port 1
- rd2  in  32  register file read data, port 2
- pc  out  32  program counter (instruction fetch address)
- pc_plus4  out  32  pc+4, the link value for JAL
- ra1  out  5  register read address 1
- ra2  out  5  register read address 2
- wa  out  5  register write address
- reg_wen  out  1  register write enable
- reg_src  out  2  write-data select: 0 ALU, 1 MEM, 2 PC(link), 3 SPI
- mem_cmd  out  2  0 NOP, 1 READ, 2 WRITE
- spi_ctrl  out  2  0 NOP, 1 SEND, 2 RECV
- alu_out  out  32  ALU result; also the data address
- carry_out  out  1  ALU carry/borrow
- is_zero  out  1  alu_out == 0
- is_syscall  out  1  opcode 0 and funct 0x0C

Behaviour:
- Reset
  - rst low forces pc=RESET_PC immediately (asynchronous).
  - While rst is low, pc_plus4 = RESET_PC + 4.
  - All other outputs stay combinational.
  - Deassertion is synchronous to clk; the first update happens on the first rising edge after release.
- PC update (rising edge, rst high), default pc+4:
  - BEQ (0x04) taken when is_zero=1.
  - BNE (0x05) taken when is_zero=0.
  - Taken branch target: pc+4 + (signext(imm16)<<2).
  - J (0x02) / JAL (0x03): target {pc_plus4[31:28], inst[25:0], 2'b00}.
  - JR (opcode 0, funct 0x08): target rd1.
  - All PC arithmetic wraps modulo 2^32.
- Decode, all combinational:
  - Defaults: ra1=rs, ra2=rt, reg_wen=0, mem_cmd=NOP, spi_ctrl=NOP, ALU op ADD, operand B = rd2.
  - Unknown opcodes: defaults, pc+4.
  - R-type (opcode 0): wa=rd, reg_wen=1, reg_src=ALU. Supported functs:
    - ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23
    - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27
    - SLT 0x2A, SLTU 0x2B
  - Shifts SLL 0x00, SRL 0x02, SRA 0x03: ra1=rt; operand B = zero-extended shamt (inst[10:6]).
  - JR and SYSCALL: reg_wen=0. SYSCALL does nothing else inside this block.
  - I-type ALU ops: wa=rt, reg_wen=1, reg_src=ALU.
    - Sign-extended immediate: ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B.
    - Zero-extended immediate: ANDI 0x0C, ORI 0x0D, XORI 0x0E.
    - LUI 0x0F: alu_out = {imm16, 16'h0}.
  - LW 0x23: ADD with signext imm, mem_cmd=READ, wa=rt, reg_wen=1, reg_src=MEM.
  - SW 0x2B: ADD with signext imm, mem_cmd=WRITE, reg_wen=0.
  - BEQ/BNE: ALU SUB rd1-rd2, reg_wen=0.
  - JAL: wa=31, reg_wen=1, reg_src=PC.
  - SPI (opcode 0x10):
    - rd field 12 → spi_ctrl=SEND, reg_wen=0.
    - rd field 15 → spi_ctrl=RECV, wa=rt, reg_wen=1, reg_src=SPI.
    - Any other rd value → NOP.
- ALU:
  - Overflow never traps; results wrap.
  - carry_out is the unsigned carry of ADD/ADDU, or the borrow (A<B unsigned) of SUB/SUBU; 0 for other ops.
  - SLT/SLTU return 32'd1 or 32'd0.
  - SRA is arithmetic; shift amount uses B[4:0].
  - is_zero is computed on every op.

Decomposition:
- Shared package: opcode/funct constants, ALU op encoding, mem_cmd/reg_src/spi_ctrl/pc_src encodings, field slice positions (OPCODE, RS, RT, RD, SHAMT, FUNCT, IMM, JADDR).
- One natural sub-module: fetch_alu_core (pure combinational ALU).
- Decoder and PC logic stay inline.

Test Plan:
- Reset mid-run: pc at 0x40, drive rst low between clock edges → pc=0x0 immediately; after release and one edge, pc=0x4.
- ADDI inst 0x2008FFFF with rd1=5 → alu_out=4, wa=8, reg_wen=1, reg_src=0; next pc=pc+4.
- BNE with rd1=3, rd2=3, imm=4 → not taken, pc+4. With rd2=2 → pc=pc+4+16.
- JAL inst 0x0C000010 at pc=0x100 → wa=31, reg_src=2, pc_plus4=0x104; next pc=0x40.
- SPI SEND inst 0x408A6000 → spi_ctrl=1, reg_wen=0. SPI RECV inst 0x408A7800 → spi_ctrl=2, wa=10, reg_wen=1, reg_src=3.
- ALU corners:
  - SUBU 0-1 → 0xFFFFFFFF, carry_out=1.
  - SRA of 0x80000000 by 4 → 0xF8000000.
  - SLTU 1<0xFFFFFFFF → 1; SLT → 0.
  - ADD 0xFFFFFFFF+1 → 0, carry_out=1, is_zero=1.

Source files
------------

// File: rtl/fetch_decode_alu_pkg.sv
// Shared encodings and instruction-field helpers for the fetch/decode/ALU front end.
package fetch_decode_alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_SPI  = 6'h10, OP_LW   = 6'h23,
                         OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_JR   = 6'h08, FN_SYSCALL = 6'h0C,
                         FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22,
                         FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
                         FN_SLTU = 6'h2B;

  localparam logic [4:0] SPI_RD_SEND = 5'd12, SPI_RD_RECV = 5'd15, LINK_REG = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} mem_cmd_e;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_PC = 2'd2, SRC_SPI = 2'd3} reg_src_e;
  typedef enum logic [1:0] {SPI_NOP = 2'd0, SPI_SEND = 2'd1, SPI_RECV = 2'd2} spi_ctrl_e;
  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG} pc_src_e;

  function automatic logic [5:0]  f_opcode(input logic [31:0] i); return i[31:26]; endfunction
  function automatic logic [4:0]  f_rs    (input logic [31:0] i); return i[25:21]; endfunction
  function automatic logic [4:0]  f_rt    (input logic [31:0] i); return i[20:16]; endfunction
  function automatic logic [4:0]  f_rd    (input logic [31:0] i); return i[15:11]; endfunction
  function automatic logic [4:0]  f_shamt (input logic [31:0] i); return i[10:6];  endfunction
  function automatic logic [5:0]  f_funct (input logic [31:0] i); return i[5:0];   endfunction
  function automatic logic [15:0] f_imm   (input logic [31:0] i); return i[15:0];  endfunction
  function automatic logic [25:0] f_jaddr (input logic [31:0] i); return i[25:0];  endfunction

endpackage

// File: rtl/fetch_decode_alu_alu.sv
// Pure combinational 32-bit ALU: wrapping arithmetic, carry/borrow flag, zero flag.
module fetch_alu_core
  import fetch_decode_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y,
  output logic        carry,
  output logic        zero
);

  logic [32:0] sum;
  logic        borrow;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign borrow = a < b;

  always_comb begin
    y     = sum[31:0];
    carry = 1'b0;
    unique case (op)
      ALU_ADD:  begin y = sum[31:0]; carry = sum[32]; end
      ALU_SUB:  begin y = a - b;     carry = borrow;  end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, borrow};
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_LUI:  y = {b[15:0], 16'h0000};
      default:  y = sum[31:0];
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/fetch_decode_alu.sv
// Single-cycle MIPS-subset front end: PC register, inline decoder, ALU instance.
module fetch_decode_alu
  import fetch_decode_alu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          W_CPU    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_CPU-1:0] inst,
  input  logic [W_CPU-1:0] rd1,
  input  logic [W_CPU-1:0] rd2,
  output logic [W_CPU-1:0] pc,
  output logic [W_CPU-1:0] pc_plus4,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  output logic [4:0]       wa,
  output logic             reg_wen,
  output logic [1:0]       reg_src,
  output logic [1:0]       mem_cmd,
  output logic [1:0]       spi_ctrl,
  output logic [W_CPU-1:0] alu_out,
  output logic             carry_out,
  output logic             is_zero,
  output logic             is_syscall
);

  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, imm_zext, alu_b, pc_next;
  alu_op_e     alu_op;
  pc_src_e     pc_src;

  assign opcode     = f_opcode(inst);
  assign funct      = f_funct(inst);
  assign imm_sext   = {{16{inst[15]}}, f_imm(inst)};
  assign imm_zext   = {16'h0000, f_imm(inst)};
  assign pc_plus4   = pc + 32'd4;
  assign is_syscall = (opcode == OP_RTYPE) && (funct == FN_SYSCALL);

  always_comb begin
    ra1      = f_rs(inst);
    ra2      = f_rt(inst);
    wa       = f_rd(inst);
    reg_wen  = 1'b0;
    reg_src  = SRC_ALU;
    mem_cmd  = MEM_NOP;
    spi_ctrl = SPI_NOP;
    alu_op   = ALU_ADD;
    alu_b    = rd2;
    pc_src   = PC_SEQ;
    unique case (opcode)
      OP_RTYPE: begin
        reg_wen = 1'b1;
        unique case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shifts read the shifted value through port 1 so A is always the source.
            ra1    = f_rt(inst);
            alu_b  = {27'd0, f_shamt(inst)};
            alu_op = (funct == FN_SLL) ? ALU_SLL : (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
          end
          FN_JR: begin reg_wen = 1'b0; pc_src = PC_REG; end
          default: reg_wen = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        wa      = f_rt(inst);
        reg_wen = 1'b1;
        alu_b   = imm_sext;
        unique case (opcode)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_ANDI:  begin alu_op = ALU_AND; alu_b = imm_zext; end
          OP_ORI:   begin alu_op = ALU_OR;  alu_b = imm_zext; end
          OP_XORI:  begin alu_op = ALU_XOR; alu_b = imm_zext; end
          OP_LUI:   begin alu_op = ALU_LUI; alu_b = imm_zext; end
          default:  alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        alu_b = imm_sext; mem_cmd = MEM_READ;
        wa = f_rt(inst); reg_wen = 1'b1; reg_src = SRC_MEM;
      end
      OP_SW: begin alu_b = imm_sext; mem_cmd = MEM_WRITE; end
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_J:   pc_src = PC_JUMP;
      OP_JAL: begin wa = LINK_REG; reg_wen = 1'b1; reg_src = SRC_PC; pc_src = PC_JUMP; end
      OP_SPI: begin
        if (f_rd(inst) == SPI_RD_SEND) spi_ctrl = SPI_SEND;
        else if (f_rd(inst) == SPI_RD_RECV) begin
          spi_ctrl = SPI_RECV; wa = f_rt(inst); reg_wen = 1'b1; reg_src = SRC_SPI;
        end
      end
      default: ;
    endcase
    // Branch decision needs the ALU zero flag, resolved after the ALU below.
    if ((opcode == OP_BEQ && is_zero) || (opcode == OP_BNE && !is_zero)) pc_src = PC_BRANCH;
  end

  fetch_alu_core u_alu (
    .a     (rd1),
    .b     (alu_b),
    .op    (alu_op),
    .y     (alu_out),
    .carry (carry_out),
    .zero  (is_zero)
  );

  always_comb begin
    unique case (pc_src)
      PC_BRANCH: pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
      PC_JUMP:   pc_next = {pc_plus4[31:28], f_jaddr(inst), 2'b00};
      PC_REG:    pc_next = rd1;
      default:   pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_next;
  end

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Directed bench: decode/ALU vector table plus hand-written PC sequences.
module tb_fetch_decode_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, rd1, rd2, pc, pc_plus4, alu_out;
  logic [4:0]  ra1, ra2, wa;
  logic        reg_wen, carry_out, is_zero, is_syscall;
  logic [1:0]  reg_src, mem_cmd, spi_ctrl;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_decode_alu #(.RESET_PC(32'h0), .W_CPU(32)) dut (
    .clk(clk), .rst(rst), .inst(inst), .rd1(rd1), .rd2(rd2),
    .pc(pc), .pc_plus4(pc_plus4), .ra1(ra1), .ra2(ra2), .wa(wa),
    .reg_wen(reg_wen), .reg_src(reg_src), .mem_cmd(mem_cmd), .spi_ctrl(spi_ctrl),
    .alu_out(alu_out), .carry_out(carry_out), .is_zero(is_zero), .is_syscall(is_syscall)
  );

  typedef struct {
    string       name;
    logic [31:0] inst, rd1, rd2;
    logic [31:0] alu;
    logic        c, z;
    logic [4:0]  wa;
    logic        wen;
    logic [1:0]  src, mem, spi;
  } vec_t;

  vec_t vecs[20];
  int   nv = 0;

  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rtf,
                                     input logic [4:0] rd, input logic [4:0] sh);
    return {6'h00, rs, rtf, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rtf,
                                     input logic [15:0] imm);
    return {op, rs, rtf, imm};
  endfunction

  task automatic add(input string nm, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] y, input logic c, input logic z, input logic [4:0] w,
                     input logic we, input logic [1:0] s, input logic [1:0] m, input logic [1:0] sp);
    vecs[nv] = '{nm, i, a, b, y, c, z, w, we, s, m, sp};
    nv++;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    add("addi",   32'h2008FFFF, 32'd5, 32'd0, 32'd4, 1, 0, 5'd8, 1, 2'd0, 2'd0, 2'd0);
    add("subu",   rt(6'h23, 5'd1, 5'd2, 5'd3, 5'd0), 32'd0, 32'd1, 32'hFFFFFFFF, 1, 0, 5'd3, 1, 2'd0, 2'd0, 2'd0);
    add("sra",    rt(6'h03, 5'd0, 5'd2, 5'd4, 5'd4), 32'h80000000, 32'd0, 32'hF8000000, 0, 0, 5'd4, 1, 2'd0, 2'd0, 2'd0);
    add("sltu",   rt(6'h2B, 5'd1, 5'd2, 5'd5, 5'd0), 32'd1, 32'hFFFFFFFF, 32'd1, 0, 0, 5'd5, 1, 2'd0, 2'd0, 2'd0);
    add("slt",    rt(6'h2A, 5'd1, 5'd2, 5'd5, 5'd0), 32'd1, 32'hFFFFFFFF, 32'd0, 0, 1, 5'd5, 1, 2'd0, 2'd0, 2'd0);
    add("add_wr", rt(6'h20, 5'd1, 5'd2, 5'd6, 5'd0), 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1, 5'd6, 1, 2'd0, 2'd0, 2'd0);
    add("sub_eq", rt(6'h22, 5'd1, 5'd2, 5'd6, 5'd0), 32'd5, 32'd5, 32'd0, 0, 1, 5'd6, 1, 2'd0, 2'd0, 2'd0);
    add("and",    rt(6'h24, 5'd1, 5'd2, 5'd7, 5'd0), 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 5'd7, 1, 2'd0, 2'd0, 2'd0);
    add("nor",    rt(6'h27, 5'd1, 5'd2, 5'd7, 5'd0), 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 5'd7, 1, 2'd0, 2'd0, 2'd0);
    add("sll",    rt(6'h00, 5'd0, 5'd2, 5'd9, 5'd8), 32'd1, 32'd0, 32'h100, 0, 0, 5'd9, 1, 2'd0, 2'd0, 2'd0);
    add("ori",    it(6'h0D, 5'd1, 5'd8, 16'h8001), 32'h10000, 32'd0, 32'h18001, 0, 0, 5'd8, 1, 2'd0, 2'd0, 2'd0);
    add("xori",   it(6'h0E, 5'd1, 5'd8, 16'hFFFF), 32'hFFFF0000, 32'd0, 32'hFFFFFFFF, 0, 0, 5'd8, 1, 2'd0, 2'd0, 2'd0);
    add("slti",   it(6'h0A, 5'd1, 5'd6, 16'hFFFF), 32'hFFFFFFFE, 32'd0, 32'd1, 0, 0, 5'd6, 1, 2'd0, 2'd0, 2'd0);
    add("lui",    it(6'h0F, 5'd0, 5'd9, 16'hABCD), 32'd0, 32'd0, 32'hABCD0000, 0, 0, 5'd9, 1, 2'd0, 2'd0, 2'd0);
    add("lw",     it(6'h23, 5'd1, 5'd7, 16'hFFFC), 32'h100, 32'd0, 32'hFC, 1, 0, 5'd7, 1, 2'd1, 2'd1, 2'd0);
    add("sw",     it(6'h2B, 5'd1, 5'd7, 16'h0008), 32'h100, 32'd0, 32'h108, 0, 0, 5'd0, 0, 2'd0, 2'd2, 2'd0);
    add("spi_tx", 32'h408A6000, 32'd0, 32'd0, 32'd0, 0, 1, 5'd0, 0, 2'd0, 2'd0, 2'd1);
    add("spi_rx", 32'h408A7800, 32'd0, 32'd0, 32'd0, 0, 1, 5'd10, 1, 2'd3, 2'd0, 2'd2);
    add("unk_op", it(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd2, 32'd3, 32'd5, 0, 0, 5'd0, 0, 2'd0, 2'd0, 2'd0);

    rst = 1'b0; inst = 32'h0; rd1 = '0; rd2 = '0;
    #2;
    check("reset_pc",     {32'd0, pc},       {32'd0, 32'h0});
    check("reset_pc4",    {32'd0, pc_plus4}, {32'd0, 32'h4});

    for (int k = 0; k < nv; k++) begin
      logic [4:0] wa_m, wa_e;
      logic [1:0] src_m, src_e;
      inst = vecs[k].inst; rd1 = vecs[k].rd1; rd2 = vecs[k].rd2;
      #1;
      // Write address and source are don't-care when nothing is written back.
      wa_m  = vecs[k].wen ? wa : 5'd0;       wa_e  = vecs[k].wen ? vecs[k].wa : 5'd0;
      src_m = vecs[k].wen ? reg_src : 2'd0;  src_e = vecs[k].wen ? vecs[k].src : 2'd0;
      check(vecs[k].name,
            {19'd0, alu_out, carry_out, is_zero, wa_m, reg_wen, src_m, mem_cmd, spi_ctrl},
            {19'd0, vecs[k].alu, vecs[k].c, vecs[k].z, wa_e, vecs[k].wen, src_e, vecs[k].mem, vecs[k].spi});
    end

    inst = 32'h0000000C; #1;
    check("syscall", {62'd0, is_syscall, reg_wen}, {62'd0, 1'b1, 1'b0});

    // Jump to 0x40, then assert reset between edges.
    @(negedge clk); rst = 1'b1; inst = 32'h08000010;
    tick();
    check("j_0x40", {32'd0, pc}, {32'd0, 32'h40});
    #2; rst = 1'b0; #1;
    check("async_rst", {32'd0, pc}, {32'd0, 32'h0});
    @(negedge clk); rst = 1'b1; inst = 32'h0;
    tick();
    check("rst_release", {32'd0, pc}, {32'd0, 32'h4});

    inst = 32'h2008FFFF; rd1 = 32'd5;
    tick();
    check("addi_pc", {32'd0, pc}, {32'd0, 32'h8});

    inst = 32'h14220004; rd1 = 32'd3; rd2 = 32'd3;
    tick();
    check("bne_not", {32'd0, pc}, {32'd0, 32'hC});
    rd2 = 32'd2;
    tick();
    check("bne_taken", {32'd0, pc}, {32'd0, 32'h20});

    inst = 32'h08000040;
    tick();
    check("j_0x100", {32'd0, pc}, {32'd0, 32'h100});
    inst = 32'h0C000010; #1;
    check("jal_dec", {24'd0, pc_plus4, wa, reg_wen, reg_src}, {24'd0, 32'h104, 5'd31, 1'b1, 2'd2});
    tick();
    check("jal_pc", {32'd0, pc}, {32'd0, 32'h40});

    inst = 32'h00600008; rd1 = 32'h1234; #1;
    check("jr_wen", {63'd0, reg_wen}, {63'd0, 1'b0});
    tick();
    check("jr_pc", {32'd0, pc}, {32'd0, 32'h1234});

    inst = it(6'h04, 5'd1, 5'd2, 16'hFFFF); rd1 = 32'd7; rd2 = 32'd7;
    tick();
    check("beq_back", {32'd0, pc}, {32'd0, 32'h1234});
    rd2 = 32'd8;
    tick();
    check("beq_not", {32'd0, pc}, {32'd0, 32'h1238});

    inst = it(6'h3F, 5'd0, 5'd0, 16'h0);
    tick();
    check("unk_pc", {32'd0, pc}, {32'd0, 32'h123C});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
